// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the packed-INT8 MAC sequencer.
// Optional feature macro: MAC_SEQ_RELU_EN (see mac_seq_ctrl).
package mac_seq_pkg;

  localparam int WORD_W    = 32;
  localparam int LANES     = 4;
  localparam int MAX_LEN_W = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_RESULT
  } state_t;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Word counter, operand address adders and one-cycle read-valid pipe.
// Ports: i_load latches bases/len, i_issue reads the current word,
//   i_flush drops the in-flight read; o_re/o_*_addr drive both memories,
//   o_last_issued flags the final word, o_data_valid marks returned data.
module mac_seq_addr_gen
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_issue,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_a_base,
  input  logic [ADDR_W-1:0] i_b_base,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_re,
  output logic [ADDR_W-1:0] o_a_addr,
  output logic [ADDR_W-1:0] o_b_addr,
  output logic              o_last_issued,
  output logic              o_data_valid
);

  logic [ADDR_W-1:0] r_a_base;
  logic [ADDR_W-1:0] r_b_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic              r_valid;
  logic [LEN_W-1:0]  w_idx_nxt;
  logic [ADDR_W-1:0] w_off;

  assign w_idx_nxt = r_idx + LEN_W'(1);
  assign w_off     = ADDR_W'(r_idx);

  // Addresses wrap naturally at 2^ADDR_W; idle bus parks at zero.
  assign o_re     = i_issue;
  assign o_a_addr = i_issue ? r_a_base + w_off : '0;
  assign o_b_addr = i_issue ? r_b_base + w_off : '0;

  // Not gated by i_issue so the FSM can use it to choose its
  // next state without a combinational loop through its own issue.
  assign o_last_issued = (w_idx_nxt == r_len);
  assign o_data_valid  = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_base <= '0;
      r_b_base <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= i_issue && !i_flush;
      if (i_load) begin
        r_a_base <= i_a_base;
        r_b_base <= i_b_base;
        r_len    <= i_len;
        r_idx    <= '0;
      end else if (i_issue) begin
        r_idx <= w_idx_nxt;
      end
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer driving the packed-INT8 MAC: clears, streams, captures result.
// Ports: start/abort/a_base/b_base/len command; mem_* operand reads;
//   clr_acc/mac_en/mac_rs* to MAC, mac_acc/mac_rd back; res_* handshake.
// Macro MAC_SEQ_RELU_EN: capture ReLU output instead of raw accumulator.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              mem_a_re,
  output logic              mem_b_re,
  output logic [ADDR_W-1:0] mem_a_addr,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [WORD_W-1:0] mem_a_rdata,
  input  logic [WORD_W-1:0] mem_b_rdata,
  output logic              clr_acc,
  output logic              mac_en,
  output logic [WORD_W-1:0] mac_rs1,
  output logic [WORD_W-1:0] mac_rs2,
  input  logic [WORD_W-1:0] mac_acc,
  input  logic [WORD_W-1:0] mac_rd,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data
);

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_len;
  logic [WORD_W-1:0] r_res;
  logic [WORD_W-1:0] w_cap;
  logic              w_accept;
  logic              w_issue;
  logic              w_re;
  logic              w_last;
  logic              w_dvalid;
  logic              w_len_nz;

  assign w_accept = (r_state == S_IDLE) && start && !abort;
  assign w_len_nz = |r_len;

`ifdef MAC_SEQ_RELU_EN
  assign w_cap = mac_rd;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^mac_rd;
  assign w_cap = mac_acc;
`endif

  mac_seq_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_accept),
    .i_issue      (w_issue),
    .i_flush      (abort),
    .i_a_base     (a_base),
    .i_b_base     (b_base),
    .i_len        (len),
    .o_re         (w_re),
    .o_a_addr     (mem_a_addr),
    .o_b_addr     (mem_b_addr),
    .o_last_issued(w_last),
    .o_data_valid (w_dvalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_len <= len;
      if (r_state == S_CAPTURE && !abort)
        r_res <= w_cap;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    clr_acc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = S_CLEAR;
      end
      S_CLEAR: begin
        clr_acc = 1'b1;
        w_issue = w_len_nz;
        if (!w_len_nz)
          w_next = S_CAPTURE;
        else if (w_last)
          w_next = S_DRAIN;
        else
          w_next = S_RUN;
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (w_last)
          w_next = S_DRAIN;
      end
      S_DRAIN:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESULT;
      S_RESULT: begin
        if (res_ready)
          w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
    // Abort silences every control pin immediately and wins over start.
    if (abort) begin
      w_next  = S_IDLE;
      w_issue = 1'b0;
      clr_acc = 1'b0;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_a_re  = w_re;
  assign mem_b_re  = w_re;
  assign mac_en    = w_dvalid && !abort;
  assign mac_rs1   = mac_en ? mem_a_rdata : '0;
  assign mac_rs2   = mac_en ? mem_b_rdata : '0;
  assign res_valid = (r_state == S_RESULT) && !abort;
  assign res_data  = r_res;

endmodule
